fsm_moore_seq_det: RTL and testbench
====================================

Name: fsm_moore_seq_det

Overview:
Parametrised Moore-type sequence detector; the successor to the fixed 2-bit-in / 2-bit-out Moore FSM.
- Scans a qualified stream of SYM_W-bit symbols for a SEQ_LEN-symbol pattern fixed at elaboration.
- Supports runtime-selectable overlapping or non-overlapping detection and a saturating match counter.
- Sits between an input symbol source and control logic that reacts to the registered match output.

Parameters:
SYM_W, 2, symbol width in bits (>=1)
SEQ_LEN, 4, pattern length in symbols (>=1)
SEQ, 8'h99, packed pattern of SEQ_LEN*SYM_W bits; symbol i = SEQ[i*SYM_W +: SYM_W]; symbol 0 is received first (default pattern 01,10,01,10)
CNT_W, 8, match counter width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  symbol qualifier; symbol consumed only when high
in  in  SYM_W  input symbol
overlap_en  in  1  1 = overlapping detection, 0 = restart after match
cnt_clr  in  1  synchronous clear of match_cnt
out  out  1  Moore match flag, high exactly while state == MATCH
state_o  out  ST_W=$clog2(SEQ_LEN+1)  current state (matched-prefix length), debug
match_cnt  out  CNT_W  saturating count of matches

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- State encoding: S0..S(SEQ_LEN-1) = number of pattern symbols matched so far; MATCH = SEQ_LEN.
- Outputs depend only on registered state (pure Moore); out = (state == SEQ_LEN); state_o = state.
- Reset (sampled at clk edge, any state, including mid-sequence): state = 0, out = 0, match_cnt = 0; all inputs ignored that cycle.
- Transition function delta(s,x), KMP style, built at elaboration:
  - if SEQ[s] == x then s+1;
  - else if s == 0 then 0;
  - else delta(fail(s), x), where fail(s) = longest proper border of SEQ[0..s-1].
- Non-MATCH state, in_valid = 0: hold.
- Non-MATCH state, in_valid = 1: next = delta(state, in).
- MATCH always lasts exactly one cycle. Let F = fail(SEQ_LEN) if overlap_en = 1, else 0 (overlap_en sampled in the MATCH cycle).
  - in_valid = 0: next = F.
  - in_valid = 1: next = delta(F, in).
  - With SEQ_LEN = 1 and a repeating symbol, MATCH may be re-entered on consecutive cycles.
- Latency: the symbol completing the pattern is sampled at edge k; out is high in cycle k+1 only.
- match_cnt increments on each transition into MATCH; it saturates at 2^CNT_W-1 and does not wrap.
- cnt_clr wins over a simultaneous increment: count becomes 0 and that match is not counted. out is unaffected.
- Illegal parameters (SEQ_LEN < 1, $bits(SEQ) != SEQ_LEN*SYM_W) are rejected by an elaboration-time $error.

Optional Feature:
FSM_MOORE_MATCH_CNT_EN
- Defined: match counter instantiated; behaves as above.
- Undefined: counter logic is removed, match_cnt is tied to 0, and cnt_clr is ignored. FSM behaviour is otherwise identical.

Decomposition:
- Package fsm_moore_pkg holds:
  - function calc_st_w(len) returning $clog2(len+1);
  - function build_fail(seq, len, w) returning the border table;
  - function build_delta(...) returning the flattened (SEQ_LEN+1) x 2^SYM_W next-state table, used as a localparam.
- Sub-module fsm_moore_sat_cnt: parametrised CNT_W saturating counter with inc/clr (clr priority) and synchronous active-high reset; instantiated under the macro.

Test Plan:
1. Default params, reset held 2 cycles, then reset released -> out=0, state_o=0, match_cnt=0; idle in_valid=0 for 5 cycles -> state_o stays 0.
2. overlap_en=1, valid stream 01,10,01,10,01,10 -> out high the cycle after the 4th and after the 6th symbol; match_cnt=2.
3. overlap_en=0, same stream -> out high only after the 4th symbol; state_o=2 after the 6th; match_cnt=1.
4. Stream 01,10,01,01,10,01,10 with in_valid gaps inserted mid-pattern -> state holds during gaps; mismatch at the 4th symbol falls back to state 1 (not 0); single match after the last symbol.
5. Reset asserted with state_o=3 -> next cycle state_o=0, out=0, match_cnt=0; the following 10 pattern is not treated as a continuation.
6. CNT_W=2, overlap_en=1, 5 back-to-back overlapping matches -> match_cnt saturates at 3. cnt_clr coincident with a match -> match_cnt=0 and out still high. Build without FSM_MOORE_MATCH_CNT_EN -> match_cnt constantly 0.

Source files
------------

// File: rtl/fsm_moore_pkg.sv
// Elaboration-time helpers for the sequence detector: state width, KMP border table and the
// flattened next-state table. Tables use fixed maximum sizes so they can be localparams.
package fsm_moore_pkg;

  localparam int unsigned MaxSeqLen = 15;
  localparam int unsigned MaxSymW   = 4;
  localparam int unsigned EntW      = 8;
  localparam int unsigned MaxStates = MaxSeqLen + 1;
  localparam int unsigned MaxSyms   = 1 << MaxSymW;

  typedef logic [MaxSeqLen*MaxSymW-1:0]       seq_vec_t;
  typedef logic [MaxStates*EntW-1:0]          fail_tab_t;
  typedef logic [MaxStates*MaxSyms*EntW-1:0]  delta_tab_t;

  function automatic int unsigned calc_st_w(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  function automatic int unsigned get_sym(input seq_vec_t seq, input int unsigned idx,
                                          input int unsigned w);
    seq_vec_t sh;
    sh = seq >> (idx * w);
    return 32'(sh[MaxSymW-1:0]) & ((32'd1 << w) - 32'd1);
  endfunction

  // Entry s holds the longest proper border of pattern prefix [0..s-1].
  function automatic fail_tab_t build_fail(input seq_vec_t seq, input int unsigned len,
                                           input int unsigned w);
    fail_tab_t   f;
    int unsigned k;
    f = '0;
    k = 0;
    for (int unsigned s = 1; s < len; s++) begin
      while (k > 0 && get_sym(seq, s, w) != get_sym(seq, k, w)) begin
        k = 32'(f[k*EntW +: EntW]);
      end
      if (get_sym(seq, s, w) == get_sym(seq, k, w)) k++;
      f[(s+1)*EntW +: EntW] = EntW'(k);
    end
    return f;
  endfunction

  // Row s, column x: next matched-prefix length from state s on symbol x.
  function automatic delta_tab_t build_delta(input seq_vec_t seq, input int unsigned len,
                                             input int unsigned w);
    delta_tab_t  d;
    fail_tab_t   f;
    int unsigned syms;
    int unsigned fs;
    d    = '0;
    f    = build_fail(seq, len, w);
    syms = 32'd1 << w;
    for (int unsigned s = 0; s <= len; s++) begin
      fs = 32'(f[s*EntW +: EntW]);
      for (int unsigned x = 0; x < syms; x++) begin
        if (s < len && get_sym(seq, s, w) == x) begin
          d[(s*syms+x)*EntW +: EntW] = EntW'(s + 1);
        end else if (s == 0) begin
          d[(s*syms+x)*EntW +: EntW] = '0;
        end else begin
          d[(s*syms+x)*EntW +: EntW] = d[(fs*syms+x)*EntW +: EntW];
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/fsm_moore_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear beats increment) and sync active-high reset.
module fsm_moore_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fsm_moore_seq_det.sv
// Parametrised Moore sequence detector with KMP-style fallback and optional match counter.
// Define FSM_MOORE_MATCH_CNT_EN to build the counter; otherwise match_cnt is tied to zero.
module fsm_moore_seq_det
  import fsm_moore_pkg::*;
#(
  parameter int unsigned SYM_W   = 2,
  parameter int unsigned SEQ_LEN = 4,
  parameter              SEQ     = 8'h99,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned ST_W   = calc_st_w(SEQ_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             out,
  output logic [ST_W-1:0]  state_o,
  output logic [CNT_W-1:0] match_cnt
);

  if (SEQ_LEN < 1 || SYM_W < 1 || $bits(SEQ) != SEQ_LEN * SYM_W ||
      SEQ_LEN > MaxSeqLen || SYM_W > MaxSymW) begin : g_bad_params
    $error("fsm_moore_seq_det: illegal SEQ_LEN/SYM_W/SEQ combination");
  end

  localparam int unsigned     Syms     = 1 << SYM_W;
  localparam logic [ST_W-1:0] MatchSt  = ST_W'(SEQ_LEN);
  localparam delta_tab_t      DeltaTab = build_delta(seq_vec_t'(SEQ), SEQ_LEN, SYM_W);
  localparam fail_tab_t       FailTab  = build_fail(seq_vec_t'(SEQ), SEQ_LEN, SYM_W);
  localparam logic [ST_W-1:0] FailSt   = ST_W'(FailTab[SEQ_LEN*EntW +: EntW]);

  logic [ST_W-1:0] state_q, state_d, base_st;
  logic [EntW-1:0] nxt_ent;

  // MATCH lasts one cycle: it first collapses to its fallback state, then consumes any symbol.
  always_comb begin
    base_st = state_q;
    if (state_q == MatchSt) begin
      base_st = overlap_en ? FailSt : '0;
    end
    nxt_ent = DeltaTab[(32'(base_st) * Syms + 32'(in)) * EntW +: EntW];
    state_d = in_valid ? ST_W'(nxt_ent) : base_st;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  assign out     = (state_q == MatchSt);
  assign state_o = state_q;

`ifdef FSM_MOORE_MATCH_CNT_EN
  fsm_moore_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_sat_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .inc_i (state_d == MatchSt),
    .clr_i (cnt_clr),
    .cnt_o (match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_fsm_moore_seq_det.sv
// Directed bench for fsm_moore_seq_det: default instance, a CNT_W=2 instance and a SEQ_LEN=1 one.
module tb_fsm_moore_seq_det;

`ifdef FSM_MOORE_MATCH_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  localparam logic [1:0] A = 2'b01;
  localparam logic [1:0] B = 2'b10;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [1:0] in_sym;
  logic       overlap_en;
  logic       cnt_clr;

  logic       out1, out2, out3;
  logic [2:0] st1, st2;
  logic [0:0] st3;
  logic [7:0] cnt1, cnt3;
  logic [1:0] cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsm_moore_seq_det u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in         (in_sym),
    .overlap_en (overlap_en),
    .cnt_clr    (cnt_clr),
    .out        (out1),
    .state_o    (st1),
    .match_cnt  (cnt1)
  );

  fsm_moore_seq_det #(
    .CNT_W (2)
  ) u_dut_c2 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in         (in_sym),
    .overlap_en (overlap_en),
    .cnt_clr    (cnt_clr),
    .out        (out2),
    .state_o    (st2),
    .match_cnt  (cnt2)
  );

  fsm_moore_seq_det #(
    .SEQ_LEN (1),
    .SEQ     (2'h3)
  ) u_dut_l1 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in         (in_sym),
    .overlap_en (overlap_en),
    .cnt_clr    (cnt_clr),
    .out        (out3),
    .state_o    (st3),
    .match_cnt  (cnt3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_sym = A; overlap_en = 1'b1; cnt_clr = 1'b0;
    tick();
    tick();
    checks++;
    if (st1 !== 3'd0 || out1 !== 1'b0 || cnt1 !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: st=%0d out=%b cnt=%0d, want 0 0 0", st1, out1, cnt1);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_sym = (i % 2 == 0) ? A : B;
      tick();
      checks++;
      if (st1 !== 3'd0 || out1 !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold[%0d]: st=%0d out=%b, want 0 0", i, st1, out1);
      end
    end
  endtask

  task automatic run_stream(input string name, input bit ovl, input int n_match);
    logic [1:0] syms [6];
    int         exp_st [6];
    syms = '{A, B, A, B, A, B};
    if (ovl) exp_st = '{1, 2, 3, 4, 3, 4};
    else     exp_st = '{1, 2, 3, 4, 1, 2};
    do_reset();
    overlap_en = ovl;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_sym   = syms[i];
      tick();
      checks++;
      if (st1 !== 3'(exp_st[i]) || out1 !== (exp_st[i] == 4)) begin
        failures++;
        $display("FAIL %s[%0d]: st=%0d out=%b, want st=%0d out=%b", name, i, st1, out1,
                 exp_st[i], exp_st[i] == 4);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (cnt1 !== (CntEn ? 8'(n_match) : 8'd0)) begin
      failures++;
      $display("FAIL %s_cnt: got %0d, want %0d", name, cnt1, CntEn ? n_match : 0);
    end
  endtask

  task automatic test_overlap();
    run_stream("overlap", 1'b1, 2);
  endtask

  task automatic test_no_overlap();
    run_stream("no_overlap", 1'b0, 1);
  endtask

  task automatic test_gaps();
    logic       vld [11];
    logic [1:0] syms [11];
    int         exp_st [11];
    vld    = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 0, 1};
    syms   = '{A, B, B, A, A, B, A, B, A, A, B};
    exp_st = '{1, 1, 2, 3, 3, 3, 1, 2, 3, 3, 4};
    do_reset();
    overlap_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = vld[i];
      in_sym   = syms[i];
      tick();
      checks++;
      if (st1 !== 3'(exp_st[i]) || out1 !== (exp_st[i] == 4)) begin
        failures++;
        $display("FAIL gaps[%0d]: st=%0d out=%b, want st=%0d out=%b", i, st1, out1,
                 exp_st[i], exp_st[i] == 4);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (cnt1 !== (CntEn ? 8'd1 : 8'd0)) begin
      failures++;
      $display("FAIL gaps_cnt: got %0d, want %0d", cnt1, CntEn ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] syms [5];
    syms = '{A, B, A, B, A};
    do_reset();
    overlap_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sym   = syms[i];
      tick();
    end
    checks++;
    if (st1 !== 3'd3 || cnt1 !== (CntEn ? 8'd1 : 8'd0)) begin
      failures++;
      $display("FAIL pre_reset: st=%0d cnt=%0d, want st=3 cnt=%0d", st1, cnt1, CntEn ? 1 : 0);
    end
    reset  = 1'b1;
    in_sym = B;
    tick();
    checks++;
    if (st1 !== 3'd0 || out1 !== 1'b0 || cnt1 !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset: st=%0d out=%b cnt=%0d, want 0 0 0", st1, out1, cnt1);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (st1 !== 3'd0 || out1 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_b: st=%0d out=%b, want 0 0", st1, out1);
    end
    in_sym = A;
    tick();
    checks++;
    if (st1 !== 3'd1) begin
      failures++;
      $display("FAIL post_reset_a: st=%0d, want 1", st1);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    overlap_en = 1'b1;
    in_valid   = 1'b1;
    in_sym = A; tick();
    in_sym = B; tick();
    for (int k = 1; k <= 5; k++) begin
      in_sym = A; tick();
      in_sym = B; tick();
      checks++;
      if (out2 !== 1'b1 || cnt2 !== (CntEn ? 2'((k > 3) ? 3 : k) : 2'd0) ||
          cnt1 !== (CntEn ? 8'(k) : 8'd0)) begin
        failures++;
        $display("FAIL saturate[%0d]: out=%b cnt2=%0d cnt8=%0d, want out=1 cnt2=%0d cnt8=%0d",
                 k, out2, cnt2, cnt1, CntEn ? ((k > 3) ? 3 : k) : 0, CntEn ? k : 0);
      end
    end
    in_sym = A; tick();
    in_sym = B; cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0;
    checks++;
    if (out2 !== 1'b1 || out1 !== 1'b1 || cnt2 !== 2'd0 || cnt1 !== 8'd0) begin
      failures++;
      $display("FAIL clr_vs_match: out=%b/%b cnt=%0d/%0d, want out=1/1 cnt=0/0",
               out1, out2, cnt1, cnt2);
    end
    in_sym = A; tick();
    in_sym = B; tick();
    in_valid = 1'b0;
    checks++;
    if (cnt2 !== (CntEn ? 2'd1 : 2'd0) || cnt1 !== (CntEn ? 8'd1 : 8'd0)) begin
      failures++;
      $display("FAIL after_clr: cnt=%0d/%0d, want %0d", cnt1, cnt2, CntEn ? 1 : 0);
    end
  endtask

  task automatic test_single_symbol();
    logic [1:0] syms [4];
    int         exp_st [4];
    syms   = '{2'h3, 2'h3, 2'h0, 2'h3};
    exp_st = '{1, 1, 0, 1};
    do_reset();
    overlap_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sym   = syms[i];
      tick();
      checks++;
      if (st3 !== 1'(exp_st[i]) || out3 !== (exp_st[i] == 1)) begin
        failures++;
        $display("FAIL len1[%0d]: st=%0d out=%b, want st=%0d out=%b", i, st3, out3,
                 exp_st[i], exp_st[i] == 1);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (cnt3 !== (CntEn ? 8'd3 : 8'd0)) begin
      failures++;
      $display("FAIL len1_cnt: got %0d, want %0d", cnt3, CntEn ? 3 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_gaps();
    test_reset_mid();
    test_saturate();
    test_single_symbol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
